// File: rtl/gfau_pkg.sv
// gfau_pkg: shared GFAU definitions.
//   OP_ADD/OP_SUB/OP_MUL/OP_INV : GFAU operation_select encodings
//   arb_state_t                 : arbiter FSM states
//   DEFAULT_WIDTH               : default operand/result width
package gfau_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} arb_state_t;
endpackage

// File: rtl/gfau_arbiter_if.sv
// gfau_arbiter_if: requester and GFAU side signals of the GFAU arbiter.
//   req_valid/req_op/req_in0/req_in1 -> arbiter, req_ready <- arbiter (packed per requester)
//   rsp_valid/rsp_result/rsp_err     <- arbiter
//   gfau_op/gfau_in0/gfau_in1/gfau_start <- arbiter, gfau_done/gfau_result -> arbiter
//   busy                             <- arbiter
//   slave modport: the arbiter; master modport: the surrounding logic
interface gfau_arbiter_if import gfau_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] req_valid, req_ready, rsp_valid;
  logic [2*NUM_REQ-1:0] req_op;
  logic [WIDTH*NUM_REQ-1:0] req_in0, req_in1;
  logic [WIDTH-1:0] rsp_result, gfau_in0, gfau_in1, gfau_result;
  logic [1:0] gfau_op;
  logic rsp_err, gfau_start, gfau_done, busy;
  modport slave (
    input req_valid, req_op, req_in0, req_in1, gfau_done, gfau_result,
    output req_ready, rsp_valid, rsp_result, rsp_err, gfau_op, gfau_in0, gfau_in1, gfau_start, busy
  );
  modport master (
    output req_valid, req_op, req_in0, req_in1, gfau_done, gfau_result,
    input req_ready, rsp_valid, rsp_result, rsp_err, gfau_op, gfau_in0, gfau_in1, gfau_start, busy
  );
endinterface

// File: rtl/gfau_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick.
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   grant : one-hot winner (first set bit at or above ptr, wrapping)
//   idx   : binary index of the winner
//   any   : at least one request present
module rr_pick #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Scanning from the farthest offset back toward ptr lets the nearest hit win.
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant = '0;
        grant[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/gfau_arbiter.sv
// gfau_arbiter: round-robin sharing of one GFAU among NUM_REQ requesters.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : requester handshake, response, GFAU drive/return, busy
//   GFAU_ARB_TIMEOUT_EN : when defined, WAIT gives up after TIMEOUT cycles with rsp_err=1
module gfau_arbiter import gfau_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input logic i_clk,
  input logic i_rst,
  gfau_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t state, state_nx;
  logic [IW-1:0] ptr, owner, win_idx;
  logic [NUM_REQ-1:0] win;
  logic [1:0] op_q;
  logic [WIDTH-1:0] in0_q, in1_q, res_q;
  logic any_req, done_in, tmo, err_q;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(bus.req_valid),
    .ptr(ptr),
    .grant(win),
    .idx(win_idx),
    .any(any_req)
  );
  assign done_in = state == S_WAIT && bus.gfau_done;
`ifdef GFAU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  always_ff @(posedge i_clk) wait_cnt <= (i_rst || state != S_WAIT) ? '0 : wait_cnt + 1'b1;
  assign tmo = state == S_WAIT && wait_cnt == CW'(TIMEOUT - 1);
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.gfau_start = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = win;
        state_nx = any_req ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        bus.gfau_start = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: state_nx = (bus.gfau_done || tmo) ? S_RESP : S_WAIT;
      default: begin
        bus.rsp_valid = NUM_REQ'(1) << owner;
        state_nx = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      ptr <= '0;
      owner <= '0;
      op_q <= '0;
      in0_q <= '0;
      in1_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && any_req) begin
        owner <= win_idx;
        op_q <= bus.req_op[2*win_idx +: 2];
        in0_q <= bus.req_in0[WIDTH*win_idx +: WIDTH];
        in1_q <= bus.req_in1[WIDTH*win_idx +: WIDTH];
      end
      if (done_in) begin
        res_q <= bus.gfau_result;
        err_q <= 1'b0;
      end else if (tmo) err_q <= 1'b1;
      if (state == S_RESP) ptr <= owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
    end
  end
  assign bus.rsp_result = res_q;
  assign bus.rsp_err = err_q;
  assign bus.gfau_op = op_q;
  assign bus.gfau_in0 = in0_q;
  assign bus.gfau_in1 = in1_q;
  assign bus.busy = state != S_IDLE;
endmodule

// File: tb/tb_gfau_arbiter.sv
// tb_gfau_arbiter: directed bench for gfau_arbiter with a latency-programmable GFAU model
module tb_gfau_arbiter;
  import gfau_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passes = 0;
  int lat = 4;
  bit gfau_en = 1'b1;
  logic [31:0] model_res = '0;
  int cnt = 0;
  gfau_arbiter_if #(.WIDTH(32), .NUM_REQ(2)) bus ();
  gfau_arbiter #(.WIDTH(32), .NUM_REQ(2), .TIMEOUT(8)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // GFAU model: done pulse 'lat' cycles after the cycle in which start is seen
  always @(posedge clk) begin
    bus.gfau_done <= 1'b0;
    bus.gfau_result <= '0;
    if (gfau_en && bus.gfau_start) begin
      if (lat == 1) begin
        bus.gfau_done <= 1'b1;
        bus.gfau_result <= model_res;
      end else cnt <= lat - 1;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        bus.gfau_done <= 1'b1;
        bus.gfau_result <= model_res;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[i] = v;
    bus.req_op[2*i +: 2] = op;
    bus.req_in0[32*i +: 32] = a;
    bus.req_in1[32*i +: 32] = b;
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_in0 = '0;
    bus.req_in1 = '0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passes++;
    checks++; if (bus.req_ready !== 2'b00) $display("FAIL reset_ready got %b want 00", bus.req_ready); else passes++;
    checks++; if (bus.rsp_valid !== 2'b00 || bus.rsp_err !== 1'b0) $display("FAIL reset_rsp got %b/%b want 00/0", bus.rsp_valid, bus.rsp_err); else passes++;
    checks++; if (bus.rsp_result !== 32'h0) $display("FAIL reset_result got %h want 0", bus.rsp_result); else passes++;
    checks++; if ({bus.gfau_start, bus.gfau_op, bus.gfau_in0, bus.gfau_in1} !== 67'h0) $display("FAIL reset_gfau got %b %b %h %h want all 0", bus.gfau_start, bus.gfau_op, bus.gfau_in0, bus.gfau_in1); else passes++;
  endtask

  task automatic test_single();
    lat = 4;
    model_res = 32'hF;
    set_req(0, 1'b1, OP_MUL, 32'h3, 32'h5);
    #1;
    checks++; if (bus.req_ready !== 2'b01) $display("FAIL single_ready got %b want 01", bus.req_ready); else passes++;
    tick();
    set_req(0, 1'b0, OP_ADD, 32'h0, 32'h0);
    checks++; if (bus.gfau_start !== 1'b1 || bus.busy !== 1'b1) $display("FAIL single_start got %b busy %b want 1 1", bus.gfau_start, bus.busy); else passes++;
    checks++; if (bus.gfau_op !== OP_MUL || bus.gfau_in0 !== 32'h3 || bus.gfau_in1 !== 32'h5) $display("FAIL single_operands got %b %h %h want 10 3 5", bus.gfau_op, bus.gfau_in0, bus.gfau_in1); else passes++;
    tick();
    checks++; if (bus.gfau_start !== 1'b0) $display("FAIL single_start_pulse got %b want 0", bus.gfau_start); else passes++;
    tick(3);
    checks++; if (bus.rsp_valid !== 2'b00 || bus.gfau_op !== OP_MUL || bus.gfau_in0 !== 32'h3) $display("FAIL single_before_rsp got %b %b %h want 00 10 3", bus.rsp_valid, bus.gfau_op, bus.gfau_in0); else passes++;
    tick();
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'hF || bus.rsp_err !== 1'b0) $display("FAIL single_rsp got %b %h %b want 01 f 0", bus.rsp_valid, bus.rsp_result, bus.rsp_err); else passes++;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.rsp_result !== 32'hF) $display("FAIL single_idle got busy %b rsp %b res %h want 0 00 f", bus.busy, bus.rsp_valid, bus.rsp_result); else passes++;
  endtask

  task automatic test_contention();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lat = 1;
    set_req(0, 1'b1, OP_ADD, 32'h100, 32'h101);
    set_req(1, 1'b1, OP_SUB, 32'h200, 32'h201);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] e;
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      model_res = 32'hA0 + k;
      #1;
      checks++; if (bus.req_ready !== e) $display("FAIL cont_ready[%0d] got %b want %b", k, bus.req_ready, e); else passes++;
      tick();
      checks++; if (bus.gfau_op !== (e[0] ? OP_ADD : OP_SUB) || bus.gfau_in0 !== (e[0] ? 32'h100 : 32'h200) || bus.gfau_in1 !== (e[0] ? 32'h101 : 32'h201)) $display("FAIL cont_operands[%0d] got %b %h %h", k, bus.gfau_op, bus.gfau_in0, bus.gfau_in1); else passes++;
      tick(2);
      checks++; if (bus.rsp_valid !== e || bus.rsp_result !== 32'hA0 + k) $display("FAIL cont_rsp[%0d] got %b %h want %b %h", k, bus.rsp_valid, bus.rsp_result, e, 32'hA0 + k); else passes++;
      tick();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_withdraw();
    int seen1 = 0;
    lat = 6;
    model_res = 32'h55;
    set_req(0, 1'b1, OP_ADD, 32'h7, 32'h9);
    #1;
    checks++; if (bus.req_ready !== 2'b01) $display("FAIL wd_ready got %b want 01", bus.req_ready); else passes++;
    tick();
    set_req(0, 1'b0, OP_ADD, 32'h0, 32'h0);
    set_req(1, 1'b1, OP_INV, 32'hDEAD, 32'h0);
    #1;
    checks++; if (bus.req_ready !== 2'b00) $display("FAIL wd_busy_ready got %b want 00", bus.req_ready); else passes++;
    tick();
    bus.req_valid = '0;
    for (int c = 2; c < 8; c++) begin
      if (bus.rsp_valid[1]) seen1++;
      tick();
    end
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'h55) $display("FAIL wd_rsp got %b %h want 01 55", bus.rsp_valid, bus.rsp_result); else passes++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.rsp_valid[1] || bus.busy) seen1++;
    end
    checks++; if (seen1 !== 0) $display("FAIL wd_no_grant got %0d stray cycles want 0", seen1); else passes++;
  endtask

  task automatic test_reset_mid_wait();
    int stray = 0;
    lat = 4;
    model_res = 32'h77;
    set_req(0, 1'b1, OP_ADD, 32'h1, 32'h2);
    set_req(1, 1'b1, OP_SUB, 32'h3, 32'h4);
    #1;
    checks++; if (bus.req_ready !== 2'b10) $display("FAIL rmw_ready got %b want 10", bus.req_ready); else passes++;
    tick();
    bus.req_valid = '0;
    tick(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.gfau_in0 !== 32'h0 || bus.gfau_op !== 2'b00 || bus.rsp_result !== 32'h0) $display("FAIL rmw_cleared got busy %b in0 %h op %b res %h want 0 0 0 0", bus.busy, bus.gfau_in0, bus.gfau_op, bus.rsp_result); else passes++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) stray++;
    end
    checks++; if (stray !== 0 || bus.rsp_result !== 32'h0) $display("FAIL rmw_late_done got %0d stray, res %h want 0 0", stray, bus.rsp_result); else passes++;
    lat = 1;
    model_res = 32'h99;
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b01) $display("FAIL rmw_ptr got %b want 01", bus.req_ready); else passes++;
    tick();
    bus.req_valid = '0;
    tick(2);
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'h99) $display("FAIL rmw_after got %b %h want 01 99", bus.rsp_valid, bus.rsp_result); else passes++;
    tick();
  endtask

  task automatic test_timeout();
`ifdef GFAU_ARB_TIMEOUT_EN
    gfau_en = 1'b0;
    set_req(0, 1'b1, OP_INV, 32'h11, 32'h0);
    tick();
    bus.req_valid = '0;
    tick(8);
    checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b1) $display("FAIL tmo_early got %b busy %b want 00 1", bus.rsp_valid, bus.busy); else passes++;
    tick();
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b1 || bus.rsp_result !== 32'h99) $display("FAIL tmo_rsp got %b err %b res %h want 01 1 99", bus.rsp_valid, bus.rsp_err, bus.rsp_result); else passes++;
    tick();
    gfau_en = 1'b1;
    lat = 8;
    model_res = 32'hBB;
    set_req(0, 1'b1, OP_INV, 32'h11, 32'h0);
    tick();
    bus.req_valid = '0;
    tick(9);
    checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_err !== 1'b0 || bus.rsp_result !== 32'hBB) $display("FAIL tmo_done_wins got %b err %b res %h want 01 0 bb", bus.rsp_valid, bus.rsp_err, bus.rsp_result); else passes++;
    tick();
`else
    int bad = 0;
    gfau_en = 1'b0;
    set_req(0, 1'b1, OP_INV, 32'h11, 32'h0);
    tick();
    bus.req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.busy !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_valid !== 2'b00) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL notmo_hold got %0d bad cycles want 0", bad); else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gfau_en = 1'b1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL notmo_recover got busy %b want 0", bus.busy); else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_withdraw();
    test_reset_mid_wait();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
